// File: rtl/prince_sbox_layer_sched.sv
// -----------------------------------------------------------------------------
// prince_sbox_layer_sched
//
// Nibble-serial scheduler for one 3-share masked PRINCE S-box core. It captures
// three input shares, feeds the core one share-triple nibble per enabled cycle,
// follows the core's register stages with a valid shift register, and collects
// the returned nibbles into three output shares. The whole pipeline freezes on
// cycles without fresh randomness, so no nibble is ever lost or duplicated.
// Shares are never combined here. Each share has its own registers and its own
// nibble mux.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   start                       single-cycle request, honoured only in IDLE
//   state_in_s0..s2   [W-1:0]   input shares, captured on an accepted start
//   state_out_s0..s2  [W-1:0]   output shares, registered
//   busy                        high in RUN and DRAIN
//   done                        one-cycle registered pulse after the last store
//   core_x_s0..s2     [3:0]     nibble shares driven into the core
//   core_y_s0..s2     [3:0]     nibble shares returned by the core
//   core_en                     advance enable for every core register stage
//   rnd_req                     fresh-mask request, high in RUN and DRAIN
//   rnd_valid                   fresh masks are available this cycle
// -----------------------------------------------------------------------------
module prince_sbox_layer_sched #(
    parameter int NIBBLES  = 16,
    parameter int SBOX_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   state_in_s0,
    input  logic [4*NIBBLES-1:0]   state_in_s1,
    input  logic [4*NIBBLES-1:0]   state_in_s2,
    output logic [4*NIBBLES-1:0]   state_out_s0,
    output logic [4*NIBBLES-1:0]   state_out_s1,
    output logic [4*NIBBLES-1:0]   state_out_s2,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             core_x_s0,
    output logic [3:0]             core_x_s1,
    output logic [3:0]             core_x_s2,
    input  logic [3:0]             core_y_s0,
    input  logic [3:0]             core_y_s1,
    input  logic [3:0]             core_y_s2,
    output logic                   core_en,
    output logic                   rnd_req,
    input  logic                   rnd_valid
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         issue_idx_q, issue_idx_d;
    logic [IW-1:0]         retire_idx_q, retire_idx_d;
    logic [SBOX_LAT-1:0]   vld_q, vld_d;
    logic [W-1:0]          in_s0_q, in_s0_d;
    logic [W-1:0]          in_s1_q, in_s1_d;
    logic [W-1:0]          in_s2_q, in_s2_d;
    logic [W-1:0]          out_s0_q, out_s0_d;
    logic [W-1:0]          out_s1_q, out_s1_d;
    logic [W-1:0]          out_s2_q, out_s2_d;
    logic                  done_q, done_d;

    logic                  active_s;
    logic                  en_s;
    logic                  issue_fire_s;
    logic                  retire_fire_s;
    logic                  last_retire_s;

    // Enable qualification: nothing moves on a cycle without fresh masks.
    always_comb begin
        active_s      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        en_s          = active_s & rnd_valid;
        issue_fire_s  = en_s & (state_q == ST_RUN);
        retire_fire_s = en_s & vld_q[SBOX_LAT-1];
        last_retire_s = retire_fire_s & (retire_idx_q == LAST_IDX);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_fire_s && (issue_idx_q == LAST_IDX)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (last_retire_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: status, enable and the per-share nibble muxes.
    always_comb begin
        busy    = active_s;
        rnd_req = active_s;
        core_en = en_s;
        case (state_q)
            ST_RUN: begin
                core_x_s0 = in_s0_q[{issue_idx_q, 2'b00} +: 4];
                core_x_s1 = in_s1_q[{issue_idx_q, 2'b00} +: 4];
                core_x_s2 = in_s2_q[{issue_idx_q, 2'b00} +: 4];
            end
            default: begin
                core_x_s0 = 4'h0;
                core_x_s1 = 4'h0;
                core_x_s2 = 4'h0;
            end
        endcase
    end

    // Datapath next-state: share capture, issue/retire indices, valid shift
    // and nibble write-back into the output shares.
    always_comb begin
        issue_idx_d  = issue_idx_q;
        retire_idx_d = retire_idx_q;
        vld_d        = vld_q;
        in_s0_d      = in_s0_q;
        in_s1_d      = in_s1_q;
        in_s2_d      = in_s2_q;
        out_s0_d     = out_s0_q;
        out_s1_d     = out_s1_q;
        out_s2_d     = out_s2_q;
        done_d       = last_retire_s;
        if ((state_q == ST_IDLE) && start) begin
            in_s0_d      = state_in_s0;
            in_s1_d      = state_in_s1;
            in_s2_d      = state_in_s2;
            issue_idx_d  = {IW{1'b0}};
            retire_idx_d = {IW{1'b0}};
            vld_d        = {SBOX_LAT{1'b0}};
        end else if (en_s) begin
            // vld tracks which core stages hold a live nibble; it shifts in
            // lock-step with the core registers so retire aligns with core_y.
            for (int j = SBOX_LAT - 1; j > 0; j--) begin
                vld_d[j] = vld_q[j-1];
            end
            vld_d[0] = issue_fire_s;
            if (issue_fire_s) begin
                issue_idx_d = issue_idx_q + IW'(1);
            end else begin
                issue_idx_d = issue_idx_q;
            end
            if (retire_fire_s) begin
                out_s0_d[{retire_idx_q, 2'b00} +: 4] = core_y_s0;
                out_s1_d[{retire_idx_q, 2'b00} +: 4] = core_y_s1;
                out_s2_d[{retire_idx_q, 2'b00} +: 4] = core_y_s2;
                retire_idx_d = retire_idx_q + IW'(1);
            end else begin
                retire_idx_d = retire_idx_q;
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_idx_q  <= {IW{1'b0}};
            retire_idx_q <= {IW{1'b0}};
            vld_q        <= {SBOX_LAT{1'b0}};
            in_s0_q      <= {W{1'b0}};
            in_s1_q      <= {W{1'b0}};
            in_s2_q      <= {W{1'b0}};
            out_s0_q     <= {W{1'b0}};
            out_s1_q     <= {W{1'b0}};
            out_s2_q     <= {W{1'b0}};
            done_q       <= 1'b0;
        end else begin
            issue_idx_q  <= issue_idx_d;
            retire_idx_q <= retire_idx_d;
            vld_q        <= vld_d;
            in_s0_q      <= in_s0_d;
            in_s1_q      <= in_s1_d;
            in_s2_q      <= in_s2_d;
            out_s0_q     <= out_s0_d;
            out_s1_q     <= out_s1_d;
            out_s2_q     <= out_s2_d;
            done_q       <= done_d;
        end
    end

    assign state_out_s0 = out_s0_q;
    assign state_out_s1 = out_s1_q;
    assign state_out_s2 = out_s2_q;
    assign done         = done_q;

endmodule

// File: doc/prince_sbox_layer_sched.md
# prince_sbox_layer_sched

Nibble-serial scheduler that drives one 3-share second-order masked PRINCE S-box core across a full 64-bit shared state. It captures three 64-bit input shares, issues one share-triple nibble per enabled cycle into the core, and tracks the core's register stages. It freezes the whole pipeline whenever fresh randomness is unavailable, collects the output nibbles into three 64-bit output shares, and pulses `done`. It sits between the round controller and the masked S-box core, which is built from the coordinate-function modules.

## Interface
- `NIBBLES`, 16: nibbles per state; the index counter width is clog2(NIBBLES).
- `SBOX_LAT`, 2: number of register stages inside the masked core, each advanced by `core_en`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `state_in_s0` / `state_in_s1` / `state_in_s2` in 64 each: input shares.
- `state_out_s0` / `state_out_s1` / `state_out_s2` out 64 each: output shares, registered.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle registered pulse after the last nibble is stored.
- `core_x_s0` / `core_x_s1` / `core_x_s2` out 4 each: nibble shares presented to the core.
- `core_y_s0` / `core_y_s1` / `core_y_s2` in 4 each: core output shares.
- `core_en` out 1: enable for all core pipeline registers.
- `rnd_req` out 1: request fresh masks; high in RUN and DRAIN.
- `rnd_valid` in 1: fresh masks are present this cycle.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- Reset values: every output is 0, both indices are 0, and the `vld` shift register (SBOX_LAT bits) is 0.
- **IDLE.** When `start`=1, capture all three input shares into the internal share registers, clear `issue_idx`, `retire_idx` and `vld`, and go to RUN. `start` is ignored in every other state.
- **Enable.** `core_en` = `rnd_valid` in RUN and DRAIN, and 0 otherwise. Pipeline advance, issue and retire happen only on edges where `core_en`=1. With `rnd_valid`=0, everything holds its value.
- **Issue (RUN).** `core_x_sK` = bits [4*issue_idx+3 : 4*issue_idx] of input share K. On an enabled edge: `vld[0]` <= 1, `issue_idx`++. When `issue_idx` = NIBBLES-1 is issued, go to DRAIN.
- **Issue outside RUN.** `core_x_sK` = 0. On enabled edges `vld[0]` <= 0.
- **Shift.** On enabled edges, `vld[j]` <= `vld[j-1]`.
- **Retire.** On an enabled edge with `vld[SBOX_LAT-1]`=1, write `core_y_sK` into nibble `retire_idx` of `state_out_sK`, then `retire_idx`++. Retire may occur in RUN or DRAIN and may coincide with an issue on the same edge.
- **Drain.** The retire of nibble NIBBLES-1 moves the FSM to DONE.
- **DONE.** `done`=1 for exactly one cycle, then the FSM returns to IDLE. `state_out_sK` holds its value until the next retire of a new operation.
- **Share separation.** Shares are never XORed or otherwise combined in this block. Each share has its own registers and its own mux.
- **Reset mid-operation.** Returns immediately to IDLE with all outputs 0. The partially written `state_out` is discarded.

## Timing
- Start edge is E0. With `rnd_valid` held at 1:
  - nibble i issues at edge E(i+1) and retires at edge E(i+1+SBOX_LAT);
  - the last retire is at E(NIBBLES+SBOX_LAT), which is E18 at the defaults;
  - `done` is high in the cycle following E18;
  - `busy` is high from after E0 through E18.
- Each low cycle of `rnd_valid` in RUN or DRAIN adds exactly one cycle to the latency and never loses or duplicates a nibble.
- `start` asserted in the DONE cycle is ignored. It is accepted the following cycle in IDLE.
- Back-to-back throughput is one operation per NIBBLES+SBOX_LAT+2 cycles.

## Test plan
- **Nominal.** Bench core model recombines the shares, applies the PRINCE S-box (B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4) and re-splits with random masks. Drive `s0`=0x0123456789ABCDEF, `s1`=`s2`=0, `rnd_valid`=1. Required: the recombined output is 0xBF32AC916780E5D4 and `done` is high in the cycle after E18.
- **Random shares.** Drive random `s1` and `s2` with `s0` = 0x0123456789ABCDEF^`s1`^`s2`. Required: the same recombined output and the same timing as the nominal case.
- **Randomness stalls.** Drop `rnd_valid` for 3 cycles during RUN and 2 cycles during DRAIN. Required: `done` arrives 5 cycles later than the nominal case, the output is unchanged, and `core_en`=0 in every stalled cycle.
- **Start while busy.** Pulse `start` with a different state during RUN and during the DONE cycle. Required: both pulses are ignored and the first result is intact. A third pulse in IDLE is accepted.
- **Reset mid-DRAIN.** Assert `rst` after E16. Required: in the same cycle, `busy`=0, all outputs are 0 and the FSM is in IDLE. A subsequent `start` completes correctly.
- **Back-to-back.** Two operations with `start` asserted in the first IDLE cycle after `done`. Required: both results are correct and the operation spacing is 20 cycles.
